// File: rtl/ex_fwd_hazard_ctrl.sv
// EX-stage operand forwarding and memory-wait freeze controller.
// Tracks EX/MEM/WB destinations and drives the two ALU-input forwarding selects.

module ex_fwd_sel (
  input  logic       ex_valid,
  input  logic       is_op,
  input  logic [2:0] src,
  input  logic       mem_valid,
  input  logic       mem_wr,
  input  logic       mem_load,
  input  logic [2:0] mem_dest,
  input  logic       wb_valid,
  input  logic       wb_wr,
  input  logic [2:0] wb_dest,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'd0;
    if (ex_valid && is_op) begin
      // Youngest producer (MEM) wins over WB.
      if (mem_valid && mem_wr && mem_dest == src)
        sel = mem_load ? 2'd3 : 2'd1;
      else if (wb_valid && wb_wr && wb_dest == src)
        sel = 2'd2;
    end
  end
endmodule

module ex_fwd_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [2:0]             id_sr1,
  input  logic [2:0]             id_sr2,
  input  logic                   id_sr1_is_op,
  input  logic                   id_sr2_is_op,
  input  logic [2:0]             id_dest,
  input  logic                   id_wr,
  input  logic                   id_mem,
  input  logic                   id_load,
  input  logic                   mem_resp,
  input  logic                   flush,
  output logic [1:0]             alu_input_one_mux_sel,
  output logic [1:0]             alu_input_two_mux_sel,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  typedef struct packed {
    logic [2:0] dest;
    logic       wr;
    logic       mem;
    logic       load;
  } sb_ent_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    vld_pipe;          // [0]=EX, [1]=MEM, [2]=WB
  sb_ent_t       ex_q, mem_q, wb_q;
  logic [1:0][2:0] ex_src;
  logic [1:0]      ex_is_op;
  logic [1:0][1:0] fwd_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_src   <= '0;
      ex_is_op <= '0;
    end else if (!stall) begin
      // Flush kills the instruction entering EX and the one entering MEM.
      vld_pipe <= {vld_pipe[1], vld_pipe[0] & ~flush, id_valid & ~flush};
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= '{dest: id_dest, wr: id_wr, mem: id_mem, load: id_load};
      ex_src   <= {id_sr2, id_sr1};
      ex_is_op <= {id_sr2_is_op, id_sr1_is_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        stall = vld_pipe[1] & mem_q.mem & ~mem_resp;
        if (stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        stall = ~mem_resp;
        if (mem_resp) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  for (genvar k = 0; k < 2; k++) begin : g_op
    ex_fwd_sel u_sel (
      .ex_valid (vld_pipe[0]),
      .is_op    (ex_is_op[k]),
      .src      (ex_src[k]),
      .mem_valid(vld_pipe[1]),
      .mem_wr   (mem_q.wr),
      .mem_load (mem_q.load),
      .mem_dest (mem_q.dest),
      .wb_valid (vld_pipe[2]),
      .wb_wr    (wb_q.wr),
      .wb_dest  (wb_q.dest),
      .sel      (fwd_sel[k])
    );
  end

  assign alu_input_one_mux_sel = fwd_sel[0];
  assign alu_input_two_mux_sel = fwd_sel[1];
endmodule
